// File: rtl/uart_tx_fifo_if.sv
// Processor-write / uart_tx-launch signal bundle for uart_tx_fifo.
// o_Overflow exists only when UART_TX_FIFO_OVF_EN is defined.
interface uart_tx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              i_Wr_DV;
  logic [7:0]        i_Wr_Byte;
  logic              i_Tx_Done;
  logic              o_Tx_DV;
  logic [7:0]        o_Tx_Byte;
  logic              o_Ready;
  logic              o_Empty;
  logic              o_Full;
  logic [ADDR_W:0]   o_Count;
`ifdef UART_TX_FIFO_OVF_EN
  logic              o_Overflow;

  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_Tx_Done,
    output o_Tx_DV, o_Tx_Byte, o_Ready, o_Empty, o_Full, o_Count, o_Overflow
  );
  modport master (
    output i_Wr_DV, i_Wr_Byte, i_Tx_Done,
    input  o_Tx_DV, o_Tx_Byte, o_Ready, o_Empty, o_Full, o_Count, o_Overflow
  );
`else
  modport slave (
    input  i_Wr_DV, i_Wr_Byte, i_Tx_Done,
    output o_Tx_DV, o_Tx_Byte, o_Ready, o_Empty, o_Full, o_Count
  );
  modport master (
    output i_Wr_DV, i_Wr_Byte, i_Tx_Done,
    input  o_Tx_DV, o_Tx_Byte, o_Ready, o_Empty, o_Full, o_Count
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that absorbs processor bursts and launches uart_tx one byte per o_Tx_Done.
// Define UART_TX_FIFO_OVF_EN to add the sticky o_Overflow flag.
module uart_tx_fifo #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned ALMOST_FULL = 12
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} txState_t;

  txState_t          state, stateNext;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0]  count, countNext;
  logic              empty, full, ready;
  logic              txDv;
  logic [7:0]        txByte;
  logic              wrAccept, pop;

  // Full is the registered flag, so a write into a full FIFO drops even alongside a pop.
  assign wrAccept = bus.i_Wr_DV && !full;

  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          stateNext = LAUNCH;
        end
      end
      LAUNCH:    stateNext = WAIT_DONE;
      WAIT_DONE: if (bus.i_Tx_Done) stateNext = GAP;
      GAP:       stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  always_comb begin
    countNext = count;
    case ({wrAccept, pop})
      2'b10:   countNext = count + CNT_W'(1);
      2'b01:   countNext = count - CNT_W'(1);
      default: countNext = count;
    endcase
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge i_Clock) begin
    if (wrAccept && !i_Reset) mem[wrPtr] <= bus.i_Wr_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state  <= IDLE;
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ready  <= 1'b1;
      txDv   <= 1'b0;
      txByte <= 8'h00;
    end else begin
      state <= stateNext;
      count <= countNext;
      empty <= (countNext == '0);
      full  <= (countNext == CNT_W'(DEPTH));
      ready <= (countNext < CNT_W'(ALMOST_FULL));
      txDv  <= pop;
      if (wrAccept) wrPtr <= wrPtr + ADDR_W'(1);
      if (pop) begin
        rdPtr  <= rdPtr + ADDR_W'(1);
        txByte <= mem[rdPtr];
      end
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic overflow;

  always_ff @(posedge i_Clock) begin
    if (i_Reset)                     overflow <= 1'b0;
    else if (bus.i_Wr_DV && full)    overflow <= 1'b1;
  end

  assign bus.o_Overflow = overflow;
`endif

  assign bus.o_Tx_DV   = txDv;
  assign bus.o_Tx_Byte = txByte;
  assign bus.o_Ready   = ready;
  assign bus.o_Empty   = empty;
  assign bus.o_Full    = full;
  assign bus.o_Count   = count;
endmodule
